// File: rtl/pbit_hist_logger_if.sv
// Histogram readout stream: one bin per valid/ready beat, tagged with its index
// and a last flag on the final bin.
interface pbit_hist_logger_if #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 32
) ();
    logic              rd_valid;
    logic              rd_ready;
    logic [N_BITS-1:0] rd_index;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_last;

    modport master (output rd_valid, rd_index, rd_data, rd_last, input rd_ready);
    modport slave  (input rd_valid, rd_index, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/pbit_hist_logger.sv
// Counts how often each p-bit output pattern occurs over NUM_SAMPLES strobes,
// then streams the saturating bin counts out and self-clears the bin memory.
module pbit_hist_logger #(
    parameter int N_BITS      = 8,
    parameter int CNT_W       = 32,
    parameter int NUM_SAMPLES = 100000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               sample_en,
    input  logic [N_BITS-1:0]  state_in,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    pbit_hist_logger_if.master rd
);
    localparam int DEPTH  = 1 << N_BITS;
    localparam int SCNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_DUMP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] clrAddr_q, clrAddr_d;
    logic [SCNT_W-1:0] sampleCnt_q, sampleCnt_d;
    logic              overflow_q, overflow_d;
    logic              afterDump_q, afterDump_d;
    logic [N_BITS:0]   nextIdx_q, nextIdx_d;
    logic              rdValid_q, rdValid_d;
    logic [N_BITS-1:0] rdIndex_q, rdIndex_d;

    logic              s1Valid_q;
    logic [N_BITS-1:0] s1Addr_q;
    logic              fwdHit_q;
    logic [CNT_W-1:0]  fwdData_q;

    logic [CNT_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]  memQ_q;

    logic              accept, dumpAdvance, lastBeatDone, ren, wrEn;
    logic [N_BITS-1:0] rdAddr, wrAddr;
    logic [CNT_W-1:0]  base, incVal, wrData;

    // The only write that can race a read of the same bin is the previous sample's, so one forwarding register suffices.
    always_comb begin
        accept       = (state_q == S_ACCUM) && sample_en;
        dumpAdvance  = (state_q == S_DUMP) && (!rdValid_q || rd.rd_ready)
                       && (nextIdx_q < (N_BITS+1)'(DEPTH));
        lastBeatDone = (state_q == S_DUMP) && rdValid_q && rd.rd_ready && (rdIndex_q == '1);
        base         = fwdHit_q ? fwdData_q : memQ_q;
        incVal       = (base == CNT_MAX) ? base : base + CNT_W'(1);
        rdAddr       = (state_q == S_DUMP) ? nextIdx_q[N_BITS-1:0] : state_in;
        ren          = accept || dumpAdvance;
        wrEn         = (state_q == S_CLEAR) || s1Valid_q;
        wrAddr       = (state_q == S_CLEAR) ? clrAddr_q : s1Addr_q;
        wrData       = (state_q == S_CLEAR) ? '0 : incVal;
    end

    always_comb begin
        state_d     = state_q;
        clrAddr_d   = clrAddr_q;
        sampleCnt_d = sampleCnt_q;
        overflow_d  = overflow_q;
        afterDump_d = afterDump_q;
        nextIdx_d   = nextIdx_q;
        rdValid_d   = rdValid_q;
        rdIndex_d   = rdIndex_q;
        if (s1Valid_q && (base == CNT_MAX)) overflow_d = 1'b1;
        case (state_q)
            S_CLEAR: begin
                clrAddr_d = clrAddr_q + N_BITS'(1);
                if (clrAddr_q == '1) state_d = afterDump_q ? S_DONE : S_IDLE;
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ACCUM;
                    sampleCnt_d = '0;
                    overflow_d  = 1'b0;
                    afterDump_d = 1'b0;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    sampleCnt_d = sampleCnt_q + SCNT_W'(1);
                    if (sampleCnt_q == SCNT_W'(NUM_SAMPLES - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                nextIdx_d = '0;
                if (!s1Valid_q) state_d = S_DUMP;
            end
            S_DUMP: begin
                // The memory output register doubles as the stream data register, so a stall simply withholds the read.
                if (dumpAdvance) begin
                    rdValid_d = 1'b1;
                    rdIndex_d = nextIdx_q[N_BITS-1:0];
                    nextIdx_d = nextIdx_q + (N_BITS+1)'(1);
                end else if (rdValid_q && rd.rd_ready) begin
                    rdValid_d = 1'b0;
                end
                if (lastBeatDone) begin
                    state_d     = S_CLEAR;
                    afterDump_d = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_CLEAR;
            clrAddr_q   <= '0;
            sampleCnt_q <= '0;
            overflow_q  <= 1'b0;
            afterDump_q <= 1'b0;
            nextIdx_q   <= '0;
            rdValid_q   <= 1'b0;
            rdIndex_q   <= '0;
            s1Valid_q   <= 1'b0;
            s1Addr_q    <= '0;
            fwdHit_q    <= 1'b0;
            fwdData_q   <= '0;
        end else begin
            state_q     <= state_d;
            clrAddr_q   <= clrAddr_d;
            sampleCnt_q <= sampleCnt_d;
            overflow_q  <= overflow_d;
            afterDump_q <= afterDump_d;
            nextIdx_q   <= nextIdx_d;
            rdValid_q   <= rdValid_d;
            rdIndex_q   <= rdIndex_d;
            s1Valid_q   <= accept;
            s1Addr_q    <= state_in;
            fwdHit_q    <= accept && s1Valid_q && (s1Addr_q == state_in);
            fwdData_q   <= incVal;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
        if (ren) memQ_q <= mem[rdAddr];
    end

    assign busy        = (state_q == S_CLEAR) || (state_q == S_ACCUM)
                         || (state_q == S_DRAIN) || (state_q == S_DUMP);
    assign done        = (state_q == S_DONE);
    assign overflow    = overflow_q;
    assign rd.rd_valid = rdValid_q;
    assign rd.rd_index = rdValid_q ? rdIndex_q : '0;
    assign rd.rd_data  = rdValid_q ? memQ_q : '0;
    assign rd.rd_last  = rdValid_q && (rdIndex_q == '1);
endmodule

// File: tb/tb_pbit_hist_logger.sv
// Drives two loggers (wide and 3-bit counters) with identical traffic and checks
// both against a plain per-bin occurrence count.
module tb_pbit_hist_logger;
    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       sampleEn;
    logic [3:0] stateIn;
    logic       rdReady;
    logic       busyA, doneA, overflowA;
    logic       busyB, doneB, overflowB;

    int         compareCount = 0;
    int         mismatchCount = 0;
    int         modelCnt [16];
    int         expIdx [2];
    logic       stalled [2];
    logic [3:0] savedIdx [2];
    logic [15:0] savedData [2];
    logic       savedLast [2];

    pbit_hist_logger_if #(.N_BITS(4), .CNT_W(16)) busA ();
    pbit_hist_logger_if #(.N_BITS(4), .CNT_W(3))  busB ();
    assign busA.rd_ready = rdReady;
    assign busB.rd_ready = rdReady;

    pbit_hist_logger #(.N_BITS(4), .CNT_W(16), .NUM_SAMPLES(10)) dutA (
        .clk(clk), .reset_n(resetN), .start(start), .sample_en(sampleEn), .state_in(stateIn),
        .busy(busyA), .done(doneA), .overflow(overflowA), .rd(busA.master)
    );
    pbit_hist_logger #(.N_BITS(4), .CNT_W(3), .NUM_SAMPLES(10)) dutB (
        .clk(clk), .reset_n(resetN), .start(start), .sample_en(sampleEn), .state_in(stateIn),
        .busy(busyB), .done(doneB), .overflow(overflowB), .rd(busB.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not reach its summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int expectedBin(input int w, input int k);
        int limit = (w == 0) ? 65535 : 7;
        return (modelCnt[k] > limit) ? limit : modelCnt[k];
    endfunction

    function automatic logic expectedOverflow(input int w);
        int limit = (w == 0) ? 65535 : 7;
        for (int k = 0; k < 16; k++) if (modelCnt[k] > limit) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [3:0] value, input int gap);
        sampleEn = 1'b1;
        stateIn  = value;
        modelCnt[value]++;
        @(negedge clk);
        sampleEn = 1'b0;
        stateIn  = 4'($urandom_range(0, 15));
        repeat (gap) @(negedge clk);
    endtask

    task automatic measureClear(input string tag, input logic expectDone);
        int n = 0;
        do begin
            start    = 1'($urandom_range(0, 1));
            sampleEn = 1'($urandom_range(0, 1));
            stateIn  = 4'($urandom_range(0, 15));
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (busyA && n < 40);
        start    = 1'b0;
        sampleEn = 1'b0;
        checkOutput({tag, "Cycles"}, 32'(n), 32'd16);
        checkOutput({tag, "BusyB"}, 32'(busyB), 32'd0);
        checkOutput({tag, "DoneA"}, 32'(doneA), 32'(expectDone));
        checkOutput({tag, "DoneB"}, 32'(doneB), 32'(expectDone));
        checkOutput({tag, "ValidA"}, 32'(busA.rd_valid), 32'd0);
        checkOutput({tag, "ValidB"}, 32'(busB.rd_valid), 32'd0);
        checkOutput({tag, "IndexA"}, 32'(busA.rd_index), 32'd0);
        checkOutput({tag, "DataA"}, 32'(busA.rd_data), 32'd0);
        checkOutput({tag, "LastA"}, 32'(busA.rd_last), 32'd0);
        checkOutput({tag, "LastB"}, 32'(busB.rd_last), 32'd0);
    endtask

    task automatic startRun();
        for (int k = 0; k < 16; k++) modelCnt[k] = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("startBusyA", 32'(busyA), 32'd1);
        checkOutput("startDoneA", 32'(doneA), 32'd0);
        checkOutput("startOverflowA", 32'(overflowA), 32'd0);
        checkOutput("startOverflowB", 32'(overflowB), 32'd0);
    endtask

    task automatic waitDump();
        int lat = 0;
        // Strobes and start pulses while the pipeline drains must be dropped.
        while (!busA.rd_valid && lat < 12) begin
            sampleEn = 1'b1;
            start    = 1'b1;
            stateIn  = 4'($urandom_range(0, 15));
            @(negedge clk);
            lat++;
        end
        sampleEn = 1'b0;
        start    = 1'b0;
        checkOutput("dumpLatencyWithin4", 32'(lat <= 4), 32'd1);
    endtask

    task automatic observeBeat(input int w, input logic v, input logic [3:0] idx,
                               input logic [15:0] data, input logic last);
        if (stalled[w]) begin
            checkOutput($sformatf("stallValid[%0d]", w), 32'(v), 32'd1);
            checkOutput($sformatf("stallIndex[%0d]", w), 32'(idx), 32'(savedIdx[w]));
            checkOutput($sformatf("stallData[%0d]", w), 32'(data), 32'(savedData[w]));
            checkOutput($sformatf("stallLast[%0d]", w), 32'(last), 32'(savedLast[w]));
        end
        stalled[w]   = v && !rdReady;
        savedIdx[w]  = idx;
        savedData[w] = data;
        savedLast[w] = last;
        if (v && rdReady) begin
            checkOutput($sformatf("beatIndex[%0d]", w), 32'(idx), 32'(expIdx[w]));
            checkOutput($sformatf("beatData[%0d] bin %0d", w, expIdx[w]), 32'(data),
                        32'(expectedBin(w, expIdx[w])));
            checkOutput($sformatf("beatLast[%0d]", w), 32'(last), 32'(expIdx[w] == 15));
            expIdx[w]++;
        end
    endtask

    task automatic runDump(input int readyPct, input int stopAt);
        int cyc = 0;
        for (int w = 0; w < 2; w++) begin
            expIdx[w]  = 0;
            stalled[w] = 1'b0;
        end
        while ((expIdx[0] < stopAt || expIdx[1] < stopAt) && cyc < 400) begin
            rdReady = (int'($urandom_range(1, 100)) <= readyPct);
            observeBeat(0, busA.rd_valid, busA.rd_index, busA.rd_data, busA.rd_last);
            observeBeat(1, busB.rd_valid, busB.rd_index, 16'(busB.rd_data), busB.rd_last);
            if (expIdx[0] < stopAt || expIdx[1] < stopAt) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("beatsSeenA", 32'(expIdx[0]), 32'(stopAt));
        checkOutput("beatsSeenB", 32'(expIdx[1]), 32'(stopAt));
        if (readyPct == 100 && stopAt == 16) checkOutput("fullRateCycles", 32'(cyc), 32'd15);
    endtask

    task automatic finishDump();
        @(negedge clk);
        rdReady = 1'b0;
        checkOutput("validFallA", 32'(busA.rd_valid), 32'd0);
        checkOutput("validFallB", 32'(busB.rd_valid), 32'd0);
        measureClear("doneDelay", 1'b1);
        checkOutput("runOverflowA", 32'(overflowA), 32'(expectedOverflow(0)));
        checkOutput("runOverflowB", 32'(overflowB), 32'(expectedOverflow(1)));
    endtask

    initial begin
        int pat [10] = '{3, 3, 7, 3, 7, 7, 7, 3, 3, 7};
        resetN   = 1'b0;
        start    = 1'b0;
        sampleEn = 1'b0;
        stateIn  = 4'd0;
        rdReady  = 1'b0;
        for (int k = 0; k < 16; k++) modelCnt[k] = 0;

        repeat (3) @(negedge clk);
        resetN = 1'b1;
        measureClear("resetClear", 1'b0);
        checkOutput("resetOverflowA", 32'(overflowA), 32'd0);
        checkOutput("resetOverflowB", 32'(overflowB), 32'd0);

        // Strobes in IDLE must not reach the histogram.
        repeat (3) begin
            sampleEn = 1'b1;
            stateIn  = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        sampleEn = 1'b0;
        checkOutput("idleBusyA", 32'(busyA), 32'd0);

        $display("[TB] run 1: ten samples of pattern 5");
        startRun();
        for (int i = 0; i < 10; i++) applyStimulus(4'd5, 0);
        waitDump();
        runDump(100, 16);
        finishDump();

        $display("[TB] run 2: interleaved 3/7 with random gaps");
        startRun();
        for (int i = 0; i < 10; i++) applyStimulus(pat[i][3:0], (i == 9) ? 0 : int'($urandom_range(0, 2)));
        waitDump();
        runDump(50, 16);
        finishDump();

        $display("[TB] run 3: saturation on pattern 2");
        startRun();
        for (int i = 0; i < 10; i++) applyStimulus(4'd2, (i == 9) ? 0 : int'($urandom_range(0, 1)));
        waitDump();
        runDump(70, 16);
        finishDump();

        $display("[TB] run 4: random samples, reset during dump");
        startRun();
        for (int i = 0; i < 10; i++)
            applyStimulus(4'($urandom_range(0, 3)), (i == 9) ? 0 : int'($urandom_range(0, 2)));
        waitDump();
        runDump(100, 6);
        @(negedge clk);
        checkOutput("preResetIndex", 32'(busA.rd_index), 32'd6);
        rdReady = 1'b0;
        resetN  = 1'b0;
        @(negedge clk);
        checkOutput("midResetValidA", 32'(busA.rd_valid), 32'd0);
        checkOutput("midResetValidB", 32'(busB.rd_valid), 32'd0);
        checkOutput("midResetDoneA", 32'(doneA), 32'd0);
        checkOutput("midResetBusyA", 32'(busyA), 32'd1);
        checkOutput("midResetBusyB", 32'(busyB), 32'd1);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        measureClear("midResetClear", 1'b0);

        $display("[TB] run 5: pattern 1 after abandoned dump");
        startRun();
        for (int i = 0; i < 10; i++) applyStimulus(4'd1, (i == 9) ? 0 : int'($urandom_range(0, 2)));
        waitDump();
        runDump(40, 16);
        finishDump();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/pbit_hist_logger.md
# pbit_hist_logger

Parametrised histogram logger for the p-bit network output vector. It counts how often each output pattern occurs over a fixed number of sample strobes, then streams the finished histogram out with a valid/ready handshake, for ILA capture or a UART/DMA readout. The block has a single clock: samples are qualified by an enable strobe rather than a derived clock. It adds start/restart control, automatic memory clearing, saturating counters and an overflow flag.

## Interface
Parameters:
- `N_BITS`, default 8: width of the observed output vector; the histogram has 2^N_BITS bins.
- `CNT_W`, default 32: width of each bin counter.
- `NUM_SAMPLES`, default 100000000: number of accepted samples per run.

Ports:
- `clk`  in  1: sole clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle pulse; begins a run when the block is in IDLE or DONE.
- `sample_en`  in  1: sample strobe; `state_in` is accepted on a clock edge where this is high and the block is in ACCUM.
- `state_in`  in  N_BITS: p-bit output vector to be binned.
- `busy`  out  1: high in CLEAR, ACCUM, DRAIN and DUMP.
- `done`  out  1: high in DONE (drives the LED).
- `overflow`  out  1: sticky; set when any bin saturates during the current run.
- `rd_valid`  out  1: histogram stream valid.
- `rd_ready`  in  1: histogram stream ready.
- `rd_index`  out  N_BITS: bin index of the current beat.
- `rd_data`  out  CNT_W: bin count of the current beat.
- `rd_last`  out  1: high on the beat for index 2^N_BITS-1.

## Operation
- States: CLEAR, IDLE, ACCUM, DRAIN, DUMP, DONE.
- Reset (`reset_n`=0 at an edge):
  - State becomes CLEAR.
  - Clear address, sample counter and overflow are zeroed.
  - All stream outputs go to 0, as do `done` and `overflow`; `busy` goes to 1.
  - Any run in progress, including a dump, is abandoned.
- CLEAR:
  - Writes 0 to bin k on cycle k, for k = 0 to 2^N_BITS-1.
  - Moves to IDLE after the last bin is written.
- After leaving CLEAR, every bin reads 0.
- IDLE:
  - `start` moves the block to ACCUM.
  - `sample_en` is ignored.
- ACCUM:
  - Each accepted sample increments `bin[state_in]` by 1 and increments the sample counter.
  - The sample counter is `$clog2(NUM_SAMPLES+1)` bits wide.
  - On the edge that accepts sample number NUM_SAMPLES, the state moves to DRAIN.
- Bin update pipeline:
  - Uses synchronous-read memory, so it must map to BRAM.
  - Read-modify-write over 2 stages, with write-to-read forwarding.
  - Back-to-back samples to the same bin, in any pattern, must each count exactly once.
- Saturation:
  - A bin at 2^CNT_W-1 holds its value.
  - The increment that would have wrapped sets `overflow`.
- DRAIN: waits until the last update has been written, then moves to DUMP.
- DUMP:
  - Streams bins in index order 0 to 2^N_BITS-1, one beat per handshake (`rd_valid && rd_ready`).
  - `rd_last` is high on the beat for index 2^N_BITS-1.
  - After the handshake on the last beat, the state moves to CLEAR, then automatically to DONE rather than IDLE.
- DONE:
  - `done`=1 and `overflow` is held.
  - `start` begins a new run: `overflow` is cleared and the state moves to ACCUM. Memory is already zero.
- `start` in any state other than IDLE or DONE is ignored.
- `sample_en` outside ACCUM is ignored.
- Samples arriving during DRAIN are dropped and are not counted.

## Timing
- CLEAR lasts exactly 2^N_BITS cycles.
  - After reset is released, `busy` stays 1 for 2^N_BITS cycles.
  - It then falls on the cycle the block enters IDLE.
- `start` sampled high at edge t: samples are accepted from edge t+1 onward.
- DRAIN: the first `rd_valid` rises no more than 4 cycles after the edge that accepts the final sample.
- Stream rules:
  - While `rd_valid` is high and `rd_ready` is low, `rd_index`, `rd_data` and `rd_last` are held stable.
  - `rd_valid` stays high until the handshake.
  - With `rd_ready` held at 1, the stream runs at 1 beat per cycle after the first beat; prefetch hides the memory read latency.
  - A full dump therefore takes 2^N_BITS + at most 2 cycles.
- `rd_valid` falls in the cycle after the last handshake.
- `done` rises 2^N_BITS cycles after that handshake, once the post-dump CLEAR finishes.
- Reset mid-operation: on the first cycle after the reset edge, `rd_valid`=0, `done`=0 and `busy`=1.

## Test plan
- Reset, N_BITS=4: `busy`=1 for exactly 16 cycles, then IDLE with `busy`=0, `done`=0 and all stream outputs at 0.
- N_BITS=4, NUM_SAMPLES=10:
  - Stimulus: `start`, then 10 consecutive `sample_en` cycles with `state_in`=5.
  - Required: dump gives bin 5 = 10 and all other bins 0, `rd_last` on index 15, `overflow`=0, then `done`=1.
- Interleaved pattern 3,3,7,3,7,7,7,3 with NUM_SAMPLES=8 and gaps of 0-2 cycles between strobes: bin 3 = 4 and bin 7 = 4, checking forwarding.
- Backpressure: `rd_ready` toggles pseudo-randomly during dump.
  - Each of the 16 indices appears exactly once, in order.
  - Outputs stay stable while stalled.
  - `rd_data` matches a scoreboard.
- CNT_W=3, NUM_SAMPLES=10, all samples pattern 2: bin 2 = 7, `overflow`=1. A following `start` clears `overflow` to 0.
- Reset asserted mid-dump at index 6:
  - Outputs are idle in the next cycle.
  - A new run with 4 samples of pattern 1 dumps bin 1 = 4 with no stale counts.
  - `start` and `sample_en` pulses during CLEAR and DRAIN have no effect.
